// File: rtl/uart_prog_loader_if.sv
// Programming bus from the UART boot loader to the CPU top level,
// plus the loader's status levels.
interface uart_prog_loader_if #(
    parameter int ADR_W = 15
);
    logic             upg_wen_o;
    logic [ADR_W-1:0] upg_adr_o;
    logic [31:0]      upg_dat_o;
    logic             upg_done_o;
    logic             upg_err_o;
    logic             busy_o;

    modport master (
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o,
        output upg_err_o,
        output busy_o
    );

    modport slave (
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o,
        input upg_err_o,
        input busy_o
    );
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives framed command/length/data blocks, writes
// little-endian words to imem/dmem and answers each block with a checksum.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADR_W        = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_pg,
    input  logic               rx,
    output logic               tx,
    uart_prog_loader_if.master upg
);

    localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int               IDX_W   = ADR_W - 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN0, S_LEN1, S_DATA, S_ACK, S_DONE, S_ERR
    } state_t;

    // receiver
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid, stop_err;

    // holding buffer
    logic       buf_full_q, buf_full_d;
    logic [7:0] buf_q, buf_d;
    logic       consume, overrun, frame_err;

    // transmitter
    logic             tx_q, tx_d;
    logic             tx_busy_q, tx_busy_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic             tx_start, tx_done;

    // main FSM and datapath
    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      len_full;
    logic [31:0]      word_q, word_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       csum_q, csum_d;
    logic             ack_go_q, ack_go_d;
    logic             wen_q, wen_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Receiver samples each bit near its centre, timed from the start edge.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    byte_valid = rx_sync_q;
                    stop_err   = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // ACK holds its byte back so the reply goes out before the next command.
    assign consume   = buf_full_q && (state_q != S_ACK);
    assign overrun   = byte_valid && buf_full_q && !consume;
    assign frame_err = stop_err || overrun;

    always_comb begin
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        if (consume) begin
            buf_full_d = 1'b0;
        end
        if (byte_valid && !overrun) begin
            buf_full_d = 1'b1;
            buf_d      = rx_shift_q;
        end
    end

    assign tx_done = tx_busy_q && (tx_cnt_q == FULL_M1) && (tx_bit_q == 4'd9);

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == FULL_M1) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end else if (tx_start) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, csum_q, 1'b0};
        end
        tx_d = tx_busy_d ? tx_shift_d[0] : 1'b1;
    end

    // Main FSM consumes at most one buffered byte per cycle.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        count_d    = count_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        ack_go_d   = ack_go_q;
        wen_d      = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
        tx_start   = 1'b0;
        len_full   = {buf_q, count_q[7:0]};
        unique case (state_q)
            S_IDLE: begin
                if (start_pg) begin
                    state_d = S_CMD;
                    csum_d  = '0;
                end
            end
            S_CMD: begin
                if (consume) begin
                    unique case (buf_q)
                        8'h49: begin sel_d = 1'b0; state_d = S_LEN0; end
                        8'h44: begin sel_d = 1'b1; state_d = S_LEN0; end
                        8'h45: state_d = S_DONE;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_LEN0: begin
                if (consume) begin
                    count_d[7:0] = buf_q;
                    state_d      = S_LEN1;
                end
            end
            S_LEN1: begin
                if (consume) begin
                    count_d    = len_full;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    state_d    = (len_full == 16'd0) ? S_ACK : S_DATA;
                end
            end
            S_DATA: begin
                if (consume) begin
                    word_d     = {buf_q, word_q[31:8]};
                    csum_d     = csum_q + buf_q;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        wen_d      = 1'b1;
                        adr_d      = {sel_q, word_idx_q};
                        dat_d      = word_d;
                        word_idx_d = word_idx_q + 1'b1;
                        count_d    = count_q - 16'd1;
                        if (count_q == 16'd1) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (!ack_go_q) begin
                    if (!tx_busy_q) begin
                        tx_start = 1'b1;
                        ack_go_d = 1'b1;
                    end
                end else if (tx_done) begin
                    ack_go_d = 1'b0;
                    csum_d   = '0;
                    state_d  = S_CMD;
                end
            end
            S_DONE: begin
                if (start_pg) begin
                    state_d = S_CMD;
                end
            end
            S_ERR: begin
                if (start_pg) begin
                    state_d = S_CMD;
                    csum_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An error wins over a word completing in the same cycle.
        if (frame_err && (state_q inside {S_CMD, S_LEN0, S_LEN1, S_DATA, S_ACK})) begin
            state_d  = S_ERR;
            wen_d    = 1'b0;
            adr_d    = adr_q;
            dat_d    = dat_q;
            ack_go_d = 1'b0;
        end

        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            count_q    <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            ack_go_q   <= 1'b0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            count_q    <= count_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            ack_go_q   <= ack_go_d;
            wen_q      <= wen_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx             = tx_q;
    assign upg.upg_wen_o  = wen_q;
    assign upg.upg_adr_o  = adr_q;
    assign upg.upg_dat_o  = dat_q;
    assign upg.upg_done_o = done_q;
    assign upg.upg_err_o  = err_q;
    assign upg.busy_o     = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed UART frames, a block-level model of
// expected writes/checksums, and a tx decoder checked against that model.
module tb_uart_prog_loader;

    localparam int CPB = 8;

    typedef struct {
        logic [14:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_pg = 1'b0;
    logic rx = 1'b1;
    logic tx;

    uart_prog_loader_if #(.ADR_W(15)) upg ();

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADR_W(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_pg (start_pg),
        .rx       (rx),
        .tx       (tx),
        .upg      (upg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    wr_t        exp_wr_q[$];
    logic [7:0] exp_ack_q[$];
    wr_t        wr_log[$];
    logic [7:0] tx_log[$];
    logic [7:0] blk[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every write strobe is matched against the model's next expected write.
    always @(negedge clk) begin
        if (rst && upg.upg_wen_o) begin
            wr_t got;
            wr_t e;
            got.adr = upg.upg_adr_o;
            got.dat = upg.upg_dat_o;
            wr_log.push_back(got);
            if (exp_wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_wen: adr %h dat %h, expected no write", got.adr, got.dat);
            end else begin
                e = exp_wr_q.pop_front();
                check_output("wen_adr", 32'(got.adr), 32'(e.adr));
                check_output("wen_dat", got.dat, e.dat);
            end
        end
    end

    // Decode checksum bytes on tx and match them to the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                logic [7:0] b;
                logic       sb;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                sb = tx;
                tx_log.push_back(b);
                check_output("tx_stop_bit", 32'(sb), 32'd1);
                if (exp_ack_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_tx: got %h, expected no byte", b);
                end else begin
                    check_output("tx_checksum", 32'(b), 32'(exp_ack_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Model: whole words from blk in arrival order, checksum = byte sum mod 256.
    task automatic send_block(input logic [7:0] cmd);
        int          words;
        logic [7:0]  sum;
        logic [15:0] len;
        wr_t         w;
        words = blk.size() / 4;
        len   = 16'(words);
        sum   = 8'd0;
        for (int i = 0; i < words; i++) begin
            w.adr = {(cmd == 8'h44), 14'(i)};
            w.dat = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
            exp_wr_q.push_back(w);
        end
        foreach (blk[i]) sum = sum + blk[i];
        exp_ack_q.push_back(sum);
        send_byte(cmd, 1'b1);
        send_byte(len[7:0], 1'b1);
        send_byte(len[15:8], 1'b1);
        foreach (blk[i]) send_byte(blk[i], 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_pg = 1'b1;
        @(negedge clk);
        start_pg = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        check_output({tag, "_pending_writes"}, 32'(exp_wr_q.size()), 32'd0);
        check_output({tag, "_pending_acks"}, 32'(exp_ack_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_tx"}, 32'(tx), 32'd1);
        check_output({tag, "_wen"}, 32'(upg.upg_wen_o), 32'd0);
        check_output({tag, "_adr"}, 32'(upg.upg_adr_o), 32'd0);
        check_output({tag, "_dat"}, upg.upg_dat_o, 32'd0);
        check_output({tag, "_done"}, 32'(upg.upg_done_o), 32'd0);
        check_output({tag, "_err"}, 32'(upg.upg_err_o), 32'd0);
        check_output({tag, "_busy"}, 32'(upg.busy_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("idle_busy", 32'(upg.busy_o), 32'd0);
        pulse_start();
        check_output("armed_busy", 32'(upg.busy_o), 32'd1);

        // Two instruction words
        blk = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00};
        send_block(8'h49);
        repeat (150) @(negedge clk);
        check_drained("s1");
        check_output("s1_wr_count", 32'(wr_log.size()), 32'd2);
        check_output("s1_wr0_adr", 32'(wr_log[0].adr), 32'h0000);
        check_output("s1_wr0_dat", wr_log[0].dat, 32'h0000_0013);
        check_output("s1_wr1_adr", 32'(wr_log[1].adr), 32'h0001);
        check_output("s1_wr1_dat", wr_log[1].dat, 32'h0000_12B7);
        check_output("s1_ack", 32'(tx_log[0]), 32'hDC);
        check_output("s1_busy_cmd", 32'(upg.busy_o), 32'd1);

        // One data word then end command
        blk = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_block(8'h44);
        send_byte(8'h45, 1'b1);
        repeat (200) @(negedge clk);
        check_drained("s2");
        check_output("s2_wr_adr", 32'(wr_log[2].adr), 32'h4000);
        check_output("s2_wr_dat", wr_log[2].dat, 32'hDEAD_BEEF);
        check_output("s2_ack", 32'(tx_log[1]), 32'h38);
        check_output("s2_done", 32'(upg.upg_done_o), 32'd1);
        check_output("s2_busy", 32'(upg.busy_o), 32'd0);
        pulse_start();
        check_output("s2_done_cleared", 32'(upg.upg_done_o), 32'd0);
        check_output("s2_rearmed_busy", 32'(upg.busy_o), 32'd1);

        // Short rx glitch must not produce a byte
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_output("glitch_err", 32'(upg.upg_err_o), 32'd0);
        check_output("glitch_busy", 32'(upg.busy_o), 32'd1);

        // Zero-length block
        blk.delete();
        send_block(8'h49);
        repeat (150) @(negedge clk);
        check_drained("s3");
        check_output("s3_wr_count", 32'(wr_log.size()), 32'd3);
        check_output("s3_ack", 32'(tx_log[2]), 32'h00);
        check_output("s3_busy_cmd", 32'(upg.busy_o), 32'd1);

        // Framing error mid-word
        send_byte(8'h49, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (10) @(negedge clk);
        check_output("ferr_err", 32'(upg.upg_err_o), 32'd1);
        check_output("ferr_busy", 32'(upg.busy_o), 32'd0);
        send_byte(8'h44, 1'b1);
        send_byte(8'h45, 1'b1);
        repeat (20) @(negedge clk);
        check_output("ferr_err_held", 32'(upg.upg_err_o), 32'd1);
        check_output("ferr_no_done", 32'(upg.upg_done_o), 32'd0);
        check_output("ferr_wr_count", 32'(wr_log.size()), 32'd3);
        pulse_start();
        check_output("ferr_err_cleared", 32'(upg.upg_err_o), 32'd0);
        check_output("ferr_rearmed_busy", 32'(upg.busy_o), 32'd1);

        // Reset in the middle of a data word
        send_byte(8'h49, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("midreset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_output("midreset_idle_busy", 32'(upg.busy_o), 32'd0);
        check_output("midreset_wr_count", 32'(wr_log.size()), 32'd3);
        pulse_start();

        blk = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00};
        send_block(8'h49);
        repeat (150) @(negedge clk);
        check_drained("replay");
        check_output("replay_wr_count", 32'(wr_log.size()), 32'd5);
        check_output("replay_wr0_dat", wr_log[3].dat, 32'h0000_0013);
        check_output("replay_wr1_adr", 32'(wr_log[4].adr), 32'h0001);
        check_output("replay_wr1_dat", wr_log[4].dat, 32'h0000_12B7);
        check_output("replay_ack", 32'(tx_log[3]), 32'hDC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
